// File: rtl/ram_write_buffer_if.sv
// ram_write_buffer_if: upstream (cache-side) request/response bundle of the
// posted-write buffer.
//   up_addr   word address shared by reads and writes
//   up_wdata  write data
//   up_write  write request
//   up_read   read request
//   up_stall  request not accepted this cycle (write into a full queue)
//   up_rdata  read data, valid with up_rvalid
//   up_rvalid read data valid, one cycle after an accepted read
// master = cache side, slave = write buffer.
interface ram_write_buffer_if #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] up_addr;
   logic [DATA_WIDTH-1:0] up_wdata;
   logic                  up_write;
   logic                  up_read;
   logic                  up_stall;
   logic [DATA_WIDTH-1:0] up_rdata;
   logic                  up_rvalid;

   modport master (
      output up_addr, up_wdata, up_write, up_read,
      input  up_stall, up_rdata, up_rvalid
   );

   modport slave (
      input  up_addr, up_wdata, up_write, up_read,
      output up_stall, up_rdata, up_rvalid
   );
endinterface

// File: rtl/ram_write_buffer.sv
// ram_write_buffer: posted-write FIFO between the data cache and the
// single-port RAM. Writes are queued in one cycle and retired in order on
// read-free cycles; reads hitting a queued address are forwarded from the
// youngest matching entry with the same one-cycle latency as a RAM read.
// Ports:
//   clk, resetN  CPU clock, synchronous active-low reset
//   up           upstream request/response bundle (slave modport)
//   ram_addr     RAM port address
//   ram_wdata    RAM write data
//   ram_write    RAM write enable
//   ram_rdata    RAM read data (registered, valid the cycle after ram_addr)
//   empty        queue holds no entries
//   count        number of occupied entries (0..DEPTH)
module ram_write_buffer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    resetN,
   ram_write_buffer_if.slave       up,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   output logic                    ram_write,
   input  logic [DATA_WIDTH-1:0]   ram_rdata,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]      head_q;
   logic [PTR_W-1:0]      tail_q;
   logic [CNT_W-1:0]      count_q;

   logic                  rvalid_q;
   logic                  hit_q;
   logic [DATA_WIDTH-1:0] hit_data_q;

   logic                  full_c;
   logic                  stall_c;
   logic                  accept_c;
   logic                  pop_c;
   logic                  fwd_hit_c;
   logic [DATA_WIDTH-1:0] fwd_data_c;
   logic [PTR_W-1:0]      scan_idx_c;

   // Queue status and handshake; held off while in reset so nothing leaks to RAM
   assign full_c   = (count_q == CNT_W'(DEPTH));
   assign stall_c  = resetN & up.up_write & full_c;
   assign accept_c = resetN & up.up_write & ~full_c;
   assign pop_c    = resetN & ~up.up_read & (count_q != '0);

   // Forwarding search: walk oldest to youngest so the last match wins
   always_comb begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
      scan_idx_c = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         scan_idx_c = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (addr_q[scan_idx_c] == up.up_addr)) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = data_q[scan_idx_c];
         end
      end
   end

   // RAM port arbitration: a read owns the port, otherwise drain the head
   always_comb begin
      ram_addr  = up.up_addr;
      ram_wdata = data_q[head_q];
      ram_write = 1'b0;
      if (pop_c) begin
         ram_addr  = addr_q[head_q];
         ram_write = 1'b1;
      end
   end

   // Entry storage; validity is tracked by head/count only
   always_ff @(posedge clk) begin
      if (accept_c) begin
         addr_q[tail_q] <= up.up_addr;
         data_q[tail_q] <= up.up_wdata;
      end
   end

   // Pointers, occupancy and read-response registers
   always_ff @(posedge clk) begin
      if (!resetN) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         rvalid_q   <= 1'b0;
         hit_q      <= 1'b0;
         hit_data_q <= '0;
      end else begin
         if (accept_c) tail_q <= tail_q + PTR_W'(1);
         if (pop_c)    head_q <= head_q + PTR_W'(1);
         case ({accept_c, pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         rvalid_q   <= up.up_read;
         hit_q      <= up.up_read & fwd_hit_c;
         hit_data_q <= fwd_data_c;
      end
   end

   assign up.up_stall  = stall_c;
   assign up.up_rvalid = rvalid_q;
   assign up.up_rdata  = rvalid_q ? (hit_q ? hit_data_q : ram_rdata) : '0;
   assign empty        = (count_q == '0);
   assign count        = count_q;

endmodule

// File: tb/tb_ram_write_buffer.sv
// tb_ram_write_buffer: drives directed and random traffic into
// ram_write_buffer with a RAM stub attached, and compares every cycle against
// a queue-based reference model holding its own copy of RAM contents.
module tb_ram_write_buffer;

   localparam int unsigned AW    = 10;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          resetN;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_write;
   logic [DW-1:0] ram_rdata;
   logic          empty;
   logic [2:0]    count;

   ram_write_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   ram_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .resetN    (resetN),
      .up        (bus.slave),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_write (ram_write),
      .ram_rdata (ram_rdata),
      .empty     (empty),
      .count     (count)
   );

   always #5 clk = ~clk;

   // RAM stub: registered read, write on enable
   logic [DW-1:0] mem [1024];
   always @(posedge clk) begin
      if (ram_write) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Reference model state
   logic [DW-1:0] gold [1024];
   ent_t          q[$];
   bit            pend_rd;
   logic [DW-1:0] pend_val;
   bit            c_rst, c_wr, c_rd;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   bit            exp_stall;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle's inputs and compare outputs with the model
   task automatic step_begin(input bit rst_n, input bit wr, input bit rd,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit            e_wr;
      logic [AW-1:0] e_addr;
      @(negedge clk);
      resetN = rst_n; bus.up_write = wr; bus.up_read = rd;
      bus.up_addr = a; bus.up_wdata = d;
      c_rst = rst_n; c_wr = wr; c_rd = rd; c_addr = a; c_wdata = d;
      #1;
      if (!rst_n) begin
         exp_stall = 1'b0;
         chk("rst_ram_write", 32'(ram_write), 32'd0);
         chk("rst_stall", 32'(bus.up_stall), 32'd0);
      end else begin
         exp_stall = wr && (q.size() == DEPTH);
         e_wr   = !rd && (q.size() > 0);
         e_addr = e_wr ? q[0].a : a;
         chk("stall", 32'(bus.up_stall), 32'(exp_stall));
         chk("ram_write", 32'(ram_write), 32'(e_wr));
         chk("ram_addr", 32'(ram_addr), 32'(e_addr));
         if (e_wr) chk("ram_wdata", 32'(ram_wdata), 32'(q[0].d));
         chk("count", 32'(count), 32'(q.size()));
         chk("empty", 32'(empty), 32'(q.size() == 0));
         chk("rvalid", 32'(bus.up_rvalid), 32'(pend_rd));
         chk("rdata", 32'(bus.up_rdata), pend_rd ? 32'(pend_val) : 32'd0);
      end
   endtask

   // Clock edge: advance the model using the inputs of the cycle just ended
   task automatic step_end();
      int  pre;
      bit  hit;
      logic [DW-1:0] v;
      @(posedge clk);
      if (!c_rst) begin
         q.delete();
         pend_rd = 1'b0;
      end else begin
         if (c_rd) begin
            hit = 1'b0; v = '0;
            foreach (q[i]) if (q[i].a == c_addr) begin hit = 1'b1; v = q[i].d; end
            pend_val = hit ? v : gold[c_addr];
         end
         pend_rd = c_rd;
         pre = q.size();
         if (!c_rd && pre > 0) begin
            gold[q[0].a] = q[0].d;
            void'(q.pop_front());
         end
         if (c_wr && pre < DEPTH) q.push_back('{c_addr, c_wdata});
      end
   endtask

   task automatic step(input bit rst_n, input bit wr, input bit rd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      step_begin(rst_n, wr, rd, a, d);
      step_end();
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      bit            hold;
      bit            wr, rd, rst;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            nmis;

      for (int i = 0; i < 1024; i++) begin mem[i] = '0; gold[i] = '0; end
      mem[10'h020] = 16'h5A5A; gold[10'h020] = 16'h5A5A;
      resetN = 1'b0; bus.up_write = 1'b0; bus.up_read = 1'b0;
      bus.up_addr = '0; bus.up_wdata = '0;
      pend_rd = 1'b0; pend_val = '0;

      // Reset and single write drain
      step(1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, 1'b0, '0, '0);
      step_begin(1'b1, 1'b1, 1'b0, 10'h005, 16'h1234);
      chk("after_rst_empty", 32'(empty), 32'd1);
      chk("after_rst_rvalid", 32'(bus.up_rvalid), 32'd0);
      chk("after_rst_rdata", 32'(bus.up_rdata), 32'd0);
      step_end();
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t1_ram_write", 32'(ram_write), 32'd1);
      chk("t1_ram_addr", 32'(ram_addr), 32'h005);
      chk("t1_ram_wdata", 32'(ram_wdata), 32'h1234);
      step_end();
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_count", 32'(count), 32'd0);
      step_end();

      // Youngest-entry forwarding
      step(1'b1, 1'b1, 1'b0, 10'h010, 16'hAAAA);
      step(1'b1, 1'b1, 1'b0, 10'h010, 16'hBBBB);
      step(1'b1, 1'b0, 1'b1, 10'h010, '0);
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t2_rvalid", 32'(bus.up_rvalid), 32'd1);
      chk("t2_rdata", 32'(bus.up_rdata), 32'hBBBB);
      step_end();
      drain();
      chk("t2_ram_010", 32'(mem[10'h010]), 32'hBBBB);

      // Full queue while reads hog the port
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 10'h3FF, 16'(16'hC000 + i));
      step_begin(1'b1, 1'b1, 1'b1, 10'h3FF, 16'hC004);
      chk("t3_stall_full", 32'(bus.up_stall), 32'd1);
      step_end();
      step_begin(1'b1, 1'b1, 1'b0, 10'h3FF, 16'hC004);
      chk("t3_stall_on_pop", 32'(bus.up_stall), 32'd1);
      chk("t3_pop", 32'(ram_write), 32'd1);
      step_end();
      step_begin(1'b1, 1'b1, 1'b1, 10'h3FF, 16'hC004);
      chk("t3_accept", 32'(bus.up_stall), 32'd0);
      step_end();
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t3_count", 32'(count), 32'd4);
      step_end();
      drain();

      // Read miss with unrelated entry queued
      step(1'b1, 1'b1, 1'b0, 10'h021, 16'hC3C3);
      step_begin(1'b1, 1'b0, 1'b1, 10'h020, '0);
      chk("t4_no_drain", 32'(ram_write), 32'd0);
      step_end();
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t4_rdata", 32'(bus.up_rdata), 32'h5A5A);
      chk("t4_drain", 32'(ram_write), 32'd1);
      chk("t4_drain_addr", 32'(ram_addr), 32'h021);
      step_end();
      drain();

      // Same-cycle write and read do not forward
      step(1'b1, 1'b1, 1'b1, 10'h030, 16'h1111);
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t5_rdata_old", 32'(bus.up_rdata), 32'h0000);
      step_end();
      step(1'b1, 1'b0, 1'b1, 10'h030, '0);
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t5_rdata_new", 32'(bus.up_rdata), 32'h1111);
      step_end();
      drain();

      // Mid-operation reset discards queued writes
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 10'(10'h060 + i), 16'hDEAD);
      step(1'b0, 1'b0, 1'b0, '0, '0);
      step_begin(1'b1, 1'b0, 1'b0, '0, '0);
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_empty", 32'(empty), 32'd1);
      chk("t6_no_write", 32'(ram_write), 32'd0);
      step_end();
      drain();
      chk("t6_ram_060", 32'(mem[10'h060]), 32'h0000);
      chk("t6_ram_062", 32'(mem[10'h062]), 32'h0000);

      // Random traffic; a stalled write is held until accepted
      hold = 1'b0; a = '0; d = '0; wr = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!hold) begin
            wr = ($urandom_range(0, 9) < 6);
            a  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                              : 10'($urandom_range(0, 15));
            d  = 16'($urandom);
         end
         rd = ($urandom_range(0, 9) < 4);
         step(!rst, wr, rd, a, d);
         hold = exp_stall;
      end
      drain();

      nmis = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== gold[i]) nmis++;
      chk("ram_contents_mismatches", 32'(nmis), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
